// File: rtl/apb_gpio_arb_pkg.sv
// Shared types and constants for the round-robin APB master.
//   arb_state_t : transaction sequencer states
//   TO_CNT_W    : width of the wait-state / timeout counter (covers TIMEOUT up to 255)
package apb_gpio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;

  localparam int TO_CNT_W = $clog2(256);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   i_req        : request vector, one bit per requester
//   i_last_grant : index of the previously served requester
//   o_grant      : one-hot grant (all zero when nothing requests)
//   o_grant_idx  : binary index of the granted requester
//   o_any        : at least one request present
module rr_arbiter
  import apb_gpio_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last_grant,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_grant_idx,
  output logic            o_any
);

  logic w_found;

  // Walk the candidates in priority order (last+1, last+2, ...); the first
  // requesting one wins. The inner loop keeps every bit select constant.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && i_req[i] && (i == ((int'(i_last_grant) + off) % NREQ))) begin
          w_found     = 1'b1;
          o_grant[i]  = 1'b1;
          o_grant_idx = IW'(i);
        end
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/apb_gpio_arb.sv
// Round-robin APB master sharing one APB slave between NREQ requesters.
// Ports:
//   clk, rstn              : clock, asynchronous active-low reset
//   req_valid/ready/write  : per-requester request handshake and direction
//   req_addr, req_wdata    : packed per-requester address / write data
//   rsp_valid              : one-hot completion pulse to the served requester
//   rsp_rdata, rsp_err     : shared response payload, valid with rsp_valid
//   psel..pwdata           : APB master outputs
//   prdata, pready, pslverr: APB slave response
module apb_gpio_arb
  import apb_gpio_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [AW-1:0]      paddr,
  output logic [DW-1:0]      pwdata,
  input  logic [DW-1:0]      prdata,
  input  logic               pready,
  input  logic               pslverr
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t          r_state;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_gidx;
  logic                r_write;
  logic [AW-1:0]       r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_rdata;
  logic                r_err;
  logic [TO_CNT_W-1:0] r_cnt;

  logic [NREQ-1:0]     w_req;
  logic [NREQ-1:0]     w_grant;
  logic [IW-1:0]       w_gidx;
  logic                w_any;
  logic                w_cap_write;
  logic [AW-1:0]       w_cap_addr;
  logic [DW-1:0]       w_cap_wdata;
  logic                w_timeout;

  // Requests are only looked at in IDLE. Gating with rstn keeps req_ready
  // low while reset is held, since the grant path is combinational.
  assign w_req = ((r_state == ST_IDLE) && rstn) ? req_valid : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last),
    .o_grant      (w_grant),
    .o_grant_idx  (w_gidx),
    .o_any        (w_any)
  );

  // One-hot mux of the granted requester's fields.
  always_comb begin
    w_cap_write = 1'b0;
    w_cap_addr  = '0;
    w_cap_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_cap_write = req_write[i];
        w_cap_addr  = req_addr[i*AW +: AW];
        w_cap_wdata = req_wdata[i*DW +: DW];
      end
    end
  end

  assign w_timeout = (r_cnt == TO_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_last  <= IW'(NREQ - 1);
      r_gidx  <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx  <= w_gidx;
            r_write <= w_cap_write;
            r_addr  <= w_cap_addr;
            r_wdata <= w_cap_wdata;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_cnt   <= '0;
          r_state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready wins over the timeout when both land in the same cycle.
          if (pready) begin
            r_rdata <= r_write ? '0 : prdata;
            r_err   <= pslverr;
            r_state <= ST_RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_last  <= r_gidx;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
  assign penable   = (r_state == ST_ACCESS);
  assign pwrite    = r_write;
  assign paddr     = r_addr;
  assign pwdata    = r_wdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (r_state == ST_RESP) && (r_gidx == IW'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_apb_gpio_arb.sv
module tb_apb_gpio_arb;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [63:0] req_addr, req_wdata;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_err, psel, penable, pwrite, pready, pslverr;

  int checks = 0;
  int errors = 0;
  int exp_last = NREQ - 1;

  always #5 clk = ~clk;

  apb_gpio_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  wr;
    logic [31:0] a0, a1, d0, d1;
    int          waits;   // pready-low cycles the slave inserts
    logic        serr;
    logic [31:0] prd;
    int          eg;      // expected granted requester
    logic [31:0] erd;
    logic        eerr;
    int          elat;    // expected cycle of rsp_valid, grant cycle = 0
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: round-robin pick starting after the last served requester.
  function automatic int rr_pick(input logic [1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (((mask >> c) & 2'd1) == 2'd1) return c;
    end
    return -1;
  endfunction

  // Reference: response and latency from the slave behaviour alone.
  function automatic vec_t model(input vec_t v, input int last);
    vec_t r;
    logic w;
    r    = v;
    r.eg = rr_pick(v.mask, last);
    w    = (((v.wr >> r.eg) & 2'd1) == 2'd1);
    if (v.waits <= TO - 1) begin
      r.elat = v.waits + 3;
      r.erd  = w ? 32'h0 : v.prd;
      r.eerr = v.serr;
    end else begin
      r.elat = TO + 2;
      r.erd  = 32'h0;
      r.eerr = 1'b1;
    end
    return r;
  endfunction

  // Runs one transaction starting from IDLE, just after a rising edge.
  task automatic apply(input int id, input vec_t v);
    logic [1:0]  oh;
    logic [31:0] ea, ed;
    logic        ew;
    int          c;
    bit          done;
    oh = (v.eg == 0) ? 2'b01 : 2'b10;
    ea = (v.eg == 0) ? v.a0 : v.a1;
    ed = (v.eg == 0) ? v.d0 : v.d1;
    ew = (v.eg == 0) ? v.wr[0] : v.wr[1];
    req_valid = v.mask;
    req_write = v.wr;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    pready = 1'b0; pslverr = 1'b0; prdata = v.prd;
    @(negedge clk);
    chk($sformatf("t%0d grant_ready", id), req_ready, oh);
    chk($sformatf("t%0d idle_psel", id), psel, 0);
    @(posedge clk); #1;
    // Requester inputs changing mid-flight must not matter.
    req_valid = 2'($urandom);
    req_write = 2'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    c = 1;
    done = 0;
    while (!done && c < 40) begin
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        done = 1;
      end else begin
        chk($sformatf("t%0d c%0d psel", id, c), psel, 1);
        chk($sformatf("t%0d c%0d penable", id, c), penable, (c >= 2));
        chk($sformatf("t%0d c%0d paddr", id, c), paddr, ea);
        chk($sformatf("t%0d c%0d pwrite", id, c), pwrite, ew);
        chk($sformatf("t%0d c%0d pwdata", id, c), pwdata, ed);
        chk($sformatf("t%0d c%0d ready_busy", id, c), req_ready, 0);
        pready  = (c >= 2) && ((c - 2) == v.waits);
        pslverr = v.serr;
        @(posedge clk); #1;
        c++;
      end
    end
    chk($sformatf("t%0d rsp_seen", id), done, 1);
    chk($sformatf("t%0d latency", id), c, v.elat);
    chk($sformatf("t%0d rsp_valid", id), rsp_valid, oh);
    chk($sformatf("t%0d rsp_rdata", id), rsp_rdata, v.erd);
    chk($sformatf("t%0d rsp_err", id), rsp_err, v.eerr);
    chk($sformatf("t%0d resp_psel", id), psel, 0);
    exp_last = v.eg;
    // Late slave response after completion must be ignored.
    req_valid = 2'b00;
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk($sformatf("t%0d after_rsp_valid", id), rsp_valid, 0);
    chk($sformatf("t%0d after_psel", id), psel, 0);
    chk($sformatf("t%0d after_rdata", id), rsp_rdata, v.erd);
    pready = 1'b0; pslverr = 1'b0;
    @(posedge clk); #1;
    $display("txn %0d grant=%0d lat=%0d rdata=0x%0h err=%0b", id, v.eg, c, rsp_rdata, rsp_err);
  endtask

  vec_t tbl [11];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //          mask  wr    a0      a1      d0      d1      wt sr prd            eg erd            eerr lat
    tbl[0]  = '{2'b01,2'b00,32'h0,  32'h0,  32'h0,  32'h0,  0, 0, 32'hA5,        0, 32'hA5,        0,   3};
    tbl[1]  = '{2'b10,2'b10,32'h0,  32'h4,  32'h0,  32'hFF, 3, 0, 32'h77,        1, 32'h0,         0,   6};
    tbl[2]  = '{2'b11,2'b00,32'h10, 32'h20, 32'h0,  32'h0,  0, 0, 32'h11,        0, 32'h11,        0,   3};
    tbl[3]  = '{2'b11,2'b00,32'h10, 32'h20, 32'h0,  32'h0,  0, 0, 32'h22,        1, 32'h22,        0,   3};
    tbl[4]  = '{2'b11,2'b00,32'h10, 32'h20, 32'h0,  32'h0,  0, 0, 32'h33,        0, 32'h33,        0,   3};
    tbl[5]  = '{2'b11,2'b00,32'h10, 32'h20, 32'h0,  32'h0,  0, 0, 32'h44,        1, 32'h44,        0,   3};
    tbl[6]  = '{2'b01,2'b00,32'h8,  32'h0,  32'h0,  32'h0,  0, 1, 32'h12345678,  0, 32'h12345678,  1,   3};
    tbl[7]  = '{2'b10,2'b00,32'h0,  32'hC,  32'h0,  32'h0,  10,0, 32'hDEAD,      1, 32'h0,         1,   6};
    tbl[8]  = '{2'b01,2'b01,32'h10, 32'h0,  32'h5A, 32'h0,  2, 1, 32'h99,        0, 32'h0,         1,   5};
    tbl[9]  = '{2'b11,2'b00,32'h14, 32'h18, 32'h0,  32'h0,  3, 0, 32'hCAFE,      1, 32'hCAFE,      0,   6};
    tbl[10] = '{2'b11,2'b11,32'h20, 32'h24, 32'h1,  32'h2,  4, 0, 32'hBEEF,      0, 32'h0,         1,   6};

    // Reset state, with requests already pending.
    rstn = 1'b0;
    req_valid = 2'b11; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset psel", psel, 0);
    chk("reset penable", penable, 0);
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset paddr", paddr, 0);
    chk("reset rsp_err", rsp_err, 0);
    rstn = 1'b1;
    req_valid = 2'b00;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) apply(i, tbl[i]);

    // Reset while in ACCESS: everything drops at once, no response.
    req_valid = 2'b10; req_write = 2'b00; req_addr = {32'h30, 32'h0};
    pready = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_access penable_before", penable, 1);
    rstn = 1'b0;
    #1;
    chk("rst_access psel", psel, 0);
    chk("rst_access penable", penable, 0);
    chk("rst_access rsp_valid", rsp_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold rsp_valid", rsp_valid, 0);
    end
    rstn = 1'b1;
    exp_last = NREQ - 1;
    @(posedge clk); #1;
    v = '{2'b11, 2'b00, 32'h40, 32'h44, 32'h0, 32'h0, 0, 0, 32'h5, 0, 32'h5, 0, 3};
    apply(100, v);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      v.mask  = 2'($urandom_range(1, 3));
      v.wr    = 2'($urandom);
      v.a0    = $urandom; v.a1 = $urandom;
      v.d0    = $urandom; v.d1 = $urandom;
      v.waits = $urandom_range(0, 6);
      v.serr  = ($urandom_range(0, 3) == 0);
      v.prd   = $urandom;
      v = model(v, exp_last);
      apply(200 + i, v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_arb.md
# apb_gpio_arb

Round-robin APB master that shares one APB slave port, normally the GPIO controller's register bank, between `NREQ` on-chip requesters. Each requester posts single read or write transactions through a valid/ready request channel. The arbiter sequences the APB SETUP and ACCESS phases and honours `pready` and `pslverr`. It returns read data and error status to the granted requester, and aborts with an error if the slave stalls too long.

## Interface
Parameters:
- `NREQ`, 2: number of requesters, 2..8
- `AW`, 32: address width
- `DW`, 32: data width
- `TIMEOUT`, 16: maximum ACCESS cycles with `pready` low before abort; 1..255

Ports:
- `clk`  in  1  single clock, all logic on the rising edge
- `rstn`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  request pending, one bit per requester
- `req_ready`  out  NREQ  one-hot accept pulse
- `req_write`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW]
- `req_wdata`  in  NREQ*DW  packed write data
- `rsp_valid`  out  NREQ  one-hot completion pulse
- `rsp_rdata`  out  DW  read data; shared by all requesters, valid with `rsp_valid`
- `rsp_err`  out  1  `pslverr` or timeout; valid with `rsp_valid`
- `psel`, `penable`, `pwrite`  out  1  APB master controls
- `paddr`  out  AW  APB address
- `pwdata`  out  DW  APB write data
- `prdata`  in  DW  APB read data
- `pready`, `pslverr`  in  1  APB slave response

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- **IDLE:** if any `req_valid` is high, grant requester g by round-robin. Search starts at (last_grant+1) mod NREQ. Pulse `req_ready[g]` in the same cycle. Register write flag, address and data from requester g. Next state: SETUP. With no request, stay in IDLE.
- **SETUP:** `psel`=1, `penable`=0. Next state: ACCESS.
- **ACCESS:** `psel`=1, `penable`=1. The timeout counter starts at 0 and increments every cycle that `pready` is low.
  - `pready`=1: capture `prdata` (reads only; writes capture 0) and `pslverr` into the response registers. Next state: RESP.
  - Counter reaches `TIMEOUT-1` with `pready` low: response is rdata=0, err=1. Deassert `psel` and `penable` on the next cycle. Next state: RESP.
- **RESP:** pulse `rsp_valid[g]` with `rsp_rdata` and `rsp_err`. Update last_grant to g. Next state: IDLE.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through the end of ACCESS.
- Requester inputs are sampled only in the IDLE grant cycle. Later changes to them have no effect on the transaction in flight.
- A requester whose `req_valid` drops before it is granted is simply skipped.
- Only one transaction is in flight at a time. There is no pipelining.

## Timing
- **Reset values:** all outputs are 0, the FSM is in IDLE, and last_grant = NREQ-1, so requester 0 wins first.
- **Zero-wait transaction:** grant in cycle 0, SETUP in cycle 1, ACCESS in cycle 2, `rsp_valid` in cycle 3. The next grant is possible in cycle 4, so minimum throughput is one transaction per 4 cycles.
- **Wait states:** each cycle with `pready`=0 in ACCESS adds one cycle of latency.
- **Timeout:** `rsp_valid` asserts `TIMEOUT`+2 cycles after SETUP, including the SETUP cycle.
- **Simultaneous requests:** strict rotation. With all requesters constantly valid, grants go 0,1,…,NREQ-1,0. No requester waits for more than NREQ-1 other transactions.
- **Late responses:** `pready` or `pslverr` arriving after a timeout abort is ignored.
- **Reset during a transaction:** outputs clear immediately, the transaction is dropped with no `rsp_valid`, and the FSM returns to IDLE.

## Structure
- Package `apb_gpio_arb_pkg` holds:
  - the FSM state enum `arb_state_t` (IDLE, SETUP, ACCESS, RESP);
  - the `TIMEOUT` counter width constant, `$clog2(256)`.
- Sub-module `rr_arbiter` (parameter `NREQ`) takes the request vector and last_grant. It returns a one-hot grant and its index, and is purely combinational.
- The top level contains the FSM, the request capture registers, the timeout counter and the response registers.

## Test plan
- **Single read, zero wait:** requester 0 reads 0x0, slave `prdata`=0x0000_00A5, `pready`=1 → `psel` in cycles 1-2, `penable` in cycle 2 only, `rsp_valid`=01 in cycle 3, `rsp_rdata`=0xA5, `rsp_err`=0.
- **Write with 3 wait states:** requester 1 writes 0x0000_00FF to 0x4 → `paddr`=0x4, `pwrite`=1 and `pwdata`=0xFF stay stable for 4 ACCESS cycles; `rsp_valid`=10 six cycles after the grant.
- **Contention:** both requesters valid continuously for 4 transactions → grants go 0,1,0,1; each `req_ready` pulses exactly once per grant.
- **Slave error:** `pslverr`=1 with `pready`=1 → `rsp_err`=1 and the read data is still returned.
- **Timeout:** `pready` held at 0 with `TIMEOUT`=4 → ACCESS lasts 4 cycles, then `psel` drops; `rsp_err`=1 and `rsp_rdata`=0; a later `pready` pulse has no effect.
- **Reset in ACCESS:** `rstn` driven low → `psel`, `penable` and `rsp_valid` go to 0 immediately; after release, requester 0 wins first.
